// File: rtl/lut_target_encoder_pkg.sv
// -----------------------------------------------------------------------------
// lut_target_encoder_pkg
// Shared constants and types for the branch-target/immediate lookup table and its
// reverse-search encoder. This file has no ports.
//   ENTRIES / IDX_W / TGT_W / IMM_W : table geometry
//   lut_entry_t                     : one table entry {tgt, imm}
//   LUT_DEFAULT                     : table contents restored by reset
//   enc_state_t                     : encoder search FSM states
// -----------------------------------------------------------------------------
package lut_target_encoder_pkg;

    localparam int unsigned ENTRIES = 8;
    localparam int unsigned IDX_W   = $clog2(ENTRIES);
    localparam int unsigned TGT_W   = 10;
    localparam int unsigned IMM_W   = 8;

    typedef struct packed {
        logic [TGT_W-1:0] tgt;
        logic [IMM_W-1:0] imm;
    } lut_entry_t;

    localparam lut_entry_t LUT_DEFAULT [ENTRIES] = '{
        '{tgt: 10'h000, imm: 8'd0},
        '{tgt: 10'h002, imm: 8'd1},
        '{tgt: 10'h1F0, imm: 8'd30},
        '{tgt: 10'h2F0, imm: 8'd64},
        '{tgt: 10'h2FF, imm: 8'd94},
        '{tgt: 10'h3F0, imm: 8'd128},
        '{tgt: 10'h3FF, imm: 8'd160},
        '{tgt: 10'h2F2, imm: 8'd192}
    };

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } enc_state_t;

endpackage

// File: rtl/lut_target_encoder_if.sv
// -----------------------------------------------------------------------------
// lut_target_encoder_if
// Bundles the table write port, the forward-read port and the search
// request/response handshakes of lut_target_encoder.
//   wr_en/wr_addr/wr_target/wr_imm : table write (master -> slave)
//   rd_addr -> rd_target/rd_imm    : combinational forward read
//   req_valid/req_ready/req_key    : search request
//   req_is_imm                     : immediate-field search select (LUT_IMM_SEARCH_EN only)
//   rsp_valid/rsp_ready/rsp_hit/rsp_idx : search response
// master = loader/harness side, slave = the encoder.
// Optional feature macro: LUT_IMM_SEARCH_EN.
// -----------------------------------------------------------------------------
interface lut_target_encoder_if;
    import lut_target_encoder_pkg::*;

    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [TGT_W-1:0] wr_target;
    logic [IMM_W-1:0] wr_imm;

    logic [IDX_W-1:0] rd_addr;
    logic [TGT_W-1:0] rd_target;
    logic [IMM_W-1:0] rd_imm;

    logic             req_valid;
    logic             req_ready;
    logic [TGT_W-1:0] req_key;
`ifdef LUT_IMM_SEARCH_EN
    logic             req_is_imm;
`endif

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_hit;
    logic [IDX_W-1:0] rsp_idx;

`ifdef LUT_IMM_SEARCH_EN
    modport master (
        output wr_en, wr_addr, wr_target, wr_imm, rd_addr,
        output req_valid, req_key, req_is_imm, rsp_ready,
        input  rd_target, rd_imm, req_ready, rsp_valid, rsp_hit, rsp_idx
    );
    modport slave (
        input  wr_en, wr_addr, wr_target, wr_imm, rd_addr,
        input  req_valid, req_key, req_is_imm, rsp_ready,
        output rd_target, rd_imm, req_ready, rsp_valid, rsp_hit, rsp_idx
    );
`else
    modport master (
        output wr_en, wr_addr, wr_target, wr_imm, rd_addr,
        output req_valid, req_key, rsp_ready,
        input  rd_target, rd_imm, req_ready, rsp_valid, rsp_hit, rsp_idx
    );
    modport slave (
        input  wr_en, wr_addr, wr_target, wr_imm, rd_addr,
        input  req_valid, req_key, rsp_ready,
        output rd_target, rd_imm, req_ready, rsp_valid, rsp_hit, rsp_idx
    );
`endif

endinterface

// File: rtl/lut_target_encoder_table.sv
// -----------------------------------------------------------------------------
// lut_target_encoder_table
// Register array holding the ENTRIES (target, immediate) pairs.
//   clk, reset            : clock; synchronous active-high reset restores LUT_DEFAULT
//   wr_en/wr_addr/...     : one-entry write per edge (reset has priority)
//   rd_addr -> rd_entry   : combinational forward read
//   scan_addr, scan_sel_imm -> scan_field : combinational read for the search
//                           comparator; returns the zero-extended immediate when
//                           scan_sel_imm is set, else the target.
// Reads see the pre-edge contents, so a compare in the same cycle as a write to
// that entry uses the old value.
// -----------------------------------------------------------------------------
module lut_target_encoder_table
    import lut_target_encoder_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [TGT_W-1:0] wr_target,
    input  logic [IMM_W-1:0] wr_imm,
    input  logic [IDX_W-1:0] rd_addr,
    output lut_entry_t       rd_entry,
    input  logic [IDX_W-1:0] scan_addr,
    input  logic             scan_sel_imm,
    output logic [TGT_W-1:0] scan_field
);

    lut_entry_t mem_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= LUT_DEFAULT[i];
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= '{tgt: wr_target, imm: wr_imm};
        end
    end

    assign rd_entry   = mem_q[rd_addr];
    assign scan_field = scan_sel_imm ? TGT_W'(mem_q[scan_addr].imm) : mem_q[scan_addr].tgt;

endmodule

// File: rtl/lut_target_encoder.sv
// -----------------------------------------------------------------------------
// lut_target_encoder
// Reverse lookup over the 8-entry target/immediate table: a search request
// carries a key, the encoder scans one entry per cycle from index 0 and answers
// with the lowest matching index (or a miss with index 0). A combinational
// forward-read port resolves pointer -> target/immediate.
//   clk   : single clock, all state on the rising edge
//   reset : synchronous, active-high; restores default table, drops any search
//   bus   : lut_target_encoder_if.slave (write, forward read, req/rsp handshakes)
// Optional feature macro: LUT_IMM_SEARCH_EN -- adds bus.req_is_imm; when latched
// high the search compares key[IMM_W-1:0] against the immediate field instead.
// Latency: hit at entry k -> rsp_valid k+2 edges after accept; miss -> ENTRIES+1.
// -----------------------------------------------------------------------------
module lut_target_encoder
    import lut_target_encoder_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    lut_target_encoder_if.slave   bus
);

    enc_state_t       state_q;
    logic [TGT_W-1:0] key_q;
    logic [IDX_W-1:0] ptr_q;
    logic             armed_q;
    logic             rsp_valid_q;
    logic             rsp_hit_q;
    logic [IDX_W-1:0] rsp_idx_q;

    logic             search_imm;
    logic [TGT_W-1:0] scan_field;
    logic [TGT_W-1:0] key_cmp;
    logic             match;
    lut_entry_t       rd_entry;

`ifdef LUT_IMM_SEARCH_EN
    logic is_imm_q;
    assign search_imm = is_imm_q;
`else
    assign search_imm = 1'b0;
`endif

    lut_target_encoder_table u_table (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (bus.wr_en),
        .wr_addr      (bus.wr_addr),
        .wr_target    (bus.wr_target),
        .wr_imm       (bus.wr_imm),
        .rd_addr      (bus.rd_addr),
        .rd_entry     (rd_entry),
        .scan_addr    (ptr_q),
        .scan_sel_imm (search_imm),
        .scan_field   (scan_field)
    );

    // Immediate search ignores the key's upper bits; the table returns the
    // immediate zero-extended, so both sides line up at full width.
    assign key_cmp = search_imm ? TGT_W'(key_q[IMM_W-1:0]) : key_q;
    assign match   = (scan_field == key_cmp);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            key_q       <= '0;
            ptr_q       <= '0;
            armed_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
`ifdef LUT_IMM_SEARCH_EN
            is_imm_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        key_q   <= bus.req_key;
`ifdef LUT_IMM_SEARCH_EN
                        is_imm_q <= bus.req_is_imm;
`endif
                        ptr_q   <= '0;
                        armed_q <= 1'b0;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    // First SCAN cycle is a setup slot with no compare; entry 0 is
                    // compared on the following edge.
                    if (!armed_q) begin
                        armed_q <= 1'b1;
                    end else if (match) begin
                        rsp_hit_q   <= 1'b1;
                        rsp_idx_q   <= ptr_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (ptr_q == IDX_W'(ENTRIES - 1)) begin
                        rsp_hit_q   <= 1'b0;
                        rsp_idx_q   <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        ptr_q <= ptr_q + IDX_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_hit   = rsp_hit_q;
    assign bus.rsp_idx   = rsp_idx_q;
    assign bus.rd_target = rd_entry.tgt;
    assign bus.rd_imm    = rd_entry.imm;

endmodule

// File: tb/tb_lut_target_encoder.sv
// -----------------------------------------------------------------------------
// tb_lut_target_encoder
// Self-checking bench for lut_target_encoder. A behavioural model keeps the table
// contents and predicts each search result and its latency from the table rules;
// a negedge process compares every visible output against it each cycle.
// Directed scenarios pin literal values; a randomized phase follows.
// Honors LUT_IMM_SEARCH_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_lut_target_encoder;
    import lut_target_encoder_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lut_target_encoder_if bus ();

    lut_target_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [TGT_W-1:0] m_tgt [ENTRIES];
    logic [IMM_W-1:0] m_imm [ENTRIES];
    logic             m_idle;
    int               m_cnt;
    logic [3:0]       m_pend;
    logic             m_rsp_valid;
    logic             m_hit;
    logic [2:0]       m_idx;
    logic             req_imm_s;

`ifdef LUT_IMM_SEARCH_EN
    assign req_imm_s = bus.req_is_imm;
`else
    assign req_imm_s = 1'b0;
`endif

    // Returns {hit, idx}: lowest entry whose selected field equals the key.
    function automatic logic [3:0] model_search(input logic [TGT_W-1:0] key, input logic is_imm);
        logic [3:0] r;
        r = 4'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (is_imm ? (m_imm[i] == key[IMM_W-1:0]) : (m_tgt[i] == key)) r = {1'b1, i[2:0]};
        end
        return r;
    endfunction

    function automatic int lat_of(input logic [3:0] r);
        return r[3] ? int'(r[2:0]) + 2 : ENTRIES + 1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_tgt[i] <= LUT_DEFAULT[i].tgt;
                m_imm[i] <= LUT_DEFAULT[i].imm;
            end
            m_idle      <= 1'b1;
            m_cnt       <= 0;
            m_rsp_valid <= 1'b0;
            m_hit       <= 1'b0;
            m_idx       <= 3'd0;
        end else begin
            if (bus.wr_en) begin
                m_tgt[bus.wr_addr] <= bus.wr_target;
                m_imm[bus.wr_addr] <= bus.wr_imm;
            end
            if (m_idle && bus.req_valid) begin
                m_pend <= model_search(bus.req_key, req_imm_s);
                m_cnt  <= lat_of(model_search(bus.req_key, req_imm_s));
                m_idle <= 1'b0;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_rsp_valid <= 1'b1;
                    m_hit       <= m_pend[3];
                    m_idx       <= m_pend[2:0];
                end
            end else if (m_rsp_valid && bus.rsp_ready) begin
                m_rsp_valid <= 1'b0;
                m_idle      <= 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(bus.req_ready), 32'(m_idle));
            check("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp_valid));
            if (m_rsp_valid) begin
                check("rsp_hit", 32'(bus.rsp_hit), 32'(m_hit));
                check("rsp_idx", 32'(bus.rsp_idx), 32'(m_idx));
            end
            check("rd_target", 32'(bus.rd_target), 32'(m_tgt[bus.rd_addr]));
            check("rd_imm", 32'(bus.rd_imm), 32'(m_imm[bus.rd_addr]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        bus.rd_addr = IDX_W'($urandom_range(0, ENTRIES - 1));
    endtask

    task automatic wr(input int addr, input logic [TGT_W-1:0] tgt, input logic [IMM_W-1:0] imm);
        bus.wr_en     = 1'b1;
        bus.wr_addr   = IDX_W'(addr);
        bus.wr_target = tgt;
        bus.wr_imm    = imm;
        tick();
        bus.wr_en     = 1'b0;
    endtask

    task automatic set_imm(input logic v);
`ifdef LUT_IMM_SEARCH_EN
        bus.req_is_imm = v;
`else
        if (v) begin end
`endif
    endtask

    task automatic search(input logic [TGT_W-1:0] key, input logic is_imm, input int hold,
                          input bit lit, input bit e_hit, input int e_idx, input int e_lat);
        int n;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.req_ready) check("ready_timeout", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_key   = key;
        set_imm(is_imm);
        tick();
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        if (!bus.rsp_valid) check("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
        if (lit) begin
            check("lit_hit", 32'(bus.rsp_hit), 32'(e_hit));
            check("lit_idx", 32'(bus.rsp_idx), 32'(e_idx));
            check("lit_latency", 32'(n), 32'(e_lat));
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            if (lit) begin
                check("held_idx", 32'(bus.rsp_idx), 32'(e_idx));
                check("held_ready", 32'(bus.req_ready), 32'd0);
            end
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        if (lit) check("ready_after_rsp", 32'(bus.req_ready), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [TGT_W-1:0] key;
        logic [3:0]       r;
        reset         = 1'b1;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_target = '0;
        bus.wr_imm    = '0;
        bus.rd_addr   = '0;
        bus.req_valid = 1'b0;
        bus.req_key   = '0;
        bus.rsp_ready = 1'b0;
        set_imm(1'b0);
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;

        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_hit", 32'(bus.rsp_hit), 32'd0);
        check("reset_rsp_idx", 32'(bus.rsp_idx), 32'd0);
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        r = model_search(10'h1F0, 1'b0);
        check("model_pin_1f0", 32'(r), 32'h0000000A);
        r = model_search(10'h3FF, 1'b0);
        check("model_pin_3ff", 32'(r), 32'h0000000E);

        // 1: hit at entry 2, four edges
        search(10'h1F0, 1'b0, 0, 1'b1, 1'b1, 2, 4);
        // 2: miss, nine edges
        search(10'h123, 1'b0, 0, 1'b1, 1'b0, 0, 9);
        // 3: duplicates resolve to lowest index
        wr(5, 10'h002, 8'd77);
        search(10'h002, 1'b0, 0, 1'b1, 1'b1, 1, 3);
        wr(1, 10'h111, 8'd5);
        search(10'h002, 1'b0, 0, 1'b1, 1'b1, 5, 7);
        // 4: back-pressure holds the response
        search(10'h3FF, 1'b0, 3, 1'b1, 1'b1, 6, 8);
        // 5: reset during scan drops the search
        bus.req_valid = 1'b1;
        bus.req_key   = 10'h2F2;
        tick();
        bus.req_valid = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.rsp_valid) check("no_rsp_after_reset", 32'(bus.rsp_valid), 32'd0);
        end
        bus.rd_addr = 3'd7;
        #1;
        check("rd7_target", 32'(bus.rd_target), 32'h2F2);
        check("rd7_imm", 32'(bus.rd_imm), 32'd192);
        bus.rd_addr = 3'd5;
        #1;
        check("rd5_target_default", 32'(bus.rd_target), 32'h3F0);
        check("req_ready_after_reset", 32'(bus.req_ready), 32'd1);
        // 6: immediate search
`ifdef LUT_IMM_SEARCH_EN
        search(10'h05E, 1'b1, 0, 1'b1, 1'b1, 4, 6);
`else
        search(10'h05E, 1'b1, 0, 1'b1, 1'b0, 0, 9);
`endif
        set_imm(1'b0);

        // randomized phase: model-checked every cycle
        for (int it = 0; it < 60; it++) begin
            for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
                if ($urandom_range(0, 1) == 1)
                    wr(int'($urandom_range(0, 7)), m_tgt[$urandom_range(0, 7)], 8'($urandom));
                else
                    wr(int'($urandom_range(0, 7)), 10'($urandom), 8'($urandom));
            end
            if ($urandom_range(0, 2) != 0) key = m_tgt[$urandom_range(0, 7)];
            else key = 10'($urandom);
`ifdef LUT_IMM_SEARCH_EN
            if ($urandom_range(0, 2) == 0) begin
                key = {2'($urandom), m_imm[$urandom_range(0, 7)]};
                search(key, 1'b1, int'($urandom_range(0, 3)), 1'b0, 1'b0, 0, 0);
            end else
`endif
            search(key, 1'b0, int'($urandom_range(0, 3)), 1'b0, 1'b0, 0, 0);
        end

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
